// File: rtl/conv3x3_stream_if.sv
// Pixel-in / result-out stream bundle of the 3x3 convolution stage.
// The master drives pixels and consumes results; the convolver is the slave.
interface conv3x3_stream_if;
    logic [7:0] pix_in;
    logic       pix_valid;
    logic [7:0] convResult;
    logic       En;

    modport master (output pix_in, output pix_valid, input convResult, input En);
    modport slave  (input pix_in, input pix_valid, output convResult, output En);
endinterface

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution over one IMG_W x IMG_H frame.
// Uses two line buffers and a 3x3 window, then a product stage and a sum/shift/clamp stage.
module conv3x3_stream #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int SHIFT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [8:0][7:0]  kernel,
    conv3x3_stream_if.slave  strm,
    output logic             busy,
    output logic             frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

    state_e          state_q, state_d;
    logic            drain_q, drain_d;
    logic            fd_q, fd_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;

    logic [8:0][7:0] kernel_q;
    logic [7:0]      lb0_q [IMG_W];
    logic [7:0]      lb1_q [IMG_W];
    logic [8:0][7:0] win_q, win_d;
    logic [2:0][7:0] newcol;
    logic signed [16:0] prod_q [9];
    logic signed [16:0] prod_d [9];
    logic signed [20:0] sum, shifted;
    logic            v1_q, en_q;
    logic [7:0]      res_q, res_d;

    logic accept, last_pix, win_done;

    assign accept   = (state_q == S_RUN) && strm.pix_valid;
    assign last_pix = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
    assign win_done = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        col_d   = col_q;
        row_d   = row_q;
        fd_d    = 1'b0;
        unique case (state_q)
            S_IDLE: if (start) begin
                state_d = S_RUN;
                col_d   = '0;
                row_d   = '0;
            end
            S_RUN: if (accept) begin
                if (last_pix) begin
                    state_d = S_DRAIN;
                    drain_d = 1'b0;
                end else if (col_q == CW'(IMG_W - 1)) begin
                    col_d = '0;
                    row_d = row_q + RW'(1);
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            // two drain cycles cover the product and sum stages
            S_DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = S_IDLE;
                    fd_d    = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            drain_q <= 1'b0;
            fd_q    <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            v1_q    <= 1'b0;
            en_q    <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            fd_q    <= fd_d;
            col_q   <= col_d;
            row_q   <= row_d;
            v1_q    <= win_done;
            en_q    <= v1_q;
            if (v1_q) res_q <= res_d;
        end
    end

    // window column: top = two rows up, mid = one row up, bottom = incoming pixel
    always_comb begin
        newcol[0] = lb1_q[col_q];
        newcol[1] = lb0_q[col_q];
        newcol[2] = strm.pix_in;
        for (int r = 0; r < 3; r++) begin
            win_d[3*r]     = win_q[3*r+1];
            win_d[3*r+1]   = win_q[3*r+2];
            win_d[3*r+2]   = newcol[r];
        end
        for (int k = 0; k < 9; k++)
            prod_d[k] = 17'($signed({1'b0, win_d[k]})) * 17'($signed(kernel_q[k]));
    end

    always_ff @(posedge clk) begin
        if (!rst && state_q == S_IDLE && start) kernel_q <= kernel;
        if (!rst && accept) begin
            lb1_q[col_q] <= lb0_q[col_q];
            lb0_q[col_q] <= strm.pix_in;
            win_q        <= win_d;
        end
        for (int k = 0; k < 9; k++) prod_q[k] <= prod_d[k];
    end

    always_comb begin
        sum = '0;
        for (int k = 0; k < 9; k++) sum = sum + 21'(prod_q[k]);
        shifted = sum >>> SHIFT;
        if (shifted[20])               res_d = 8'h00;
        else if (shifted > 21'sd255)   res_d = 8'hFF;
        else                           res_d = shifted[7:0];
    end

    assign strm.convResult = res_q;
    assign strm.En         = en_q;
    assign busy            = (state_q != S_IDLE);
    assign frame_done      = fd_q;
endmodule

// File: tb/tb_conv3x3_stream.sv
// Bench for conv3x3_stream: a SHIFT=0 and a SHIFT=3 instance see identical stimulus;
// results are checked against a frame-image model through per-instance scoreboards.
module tb_conv3x3_stream;
    localparam int W    = 8;
    localparam int H    = 8;
    localparam int NWIN = (W - 2) * (H - 2);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [8:0][7:0] kernel = '0;
    logic            busy0, busy3, fd0, fd3;

    conv3x3_stream_if bus0 ();
    conv3x3_stream_if bus3 ();

    conv3x3_stream #(.IMG_W(W), .IMG_H(H), .SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .kernel(kernel),
        .strm(bus0.slave), .busy(busy0), .frame_done(fd0));
    conv3x3_stream #(.IMG_W(W), .IMG_H(H), .SHIFT(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .kernel(kernel),
        .strm(bus3.slave), .busy(busy3), .frame_done(fd3));

    always #5 clk = ~clk;

    typedef struct { int val; int due; } exp_t;
    typedef struct {
        logic [8:0][7:0] k;
        int pmode;            // 0: ramp 8*row+col, 1: constant pval
        int pval;
        bit gap;
        bit disturb;
        int first0, last0, first3, last3;
    } vec_t;

    exp_t q0[$], q3[$];
    int   log0[$], log3[$];
    int   n_vec = 0, n_err = 0;
    int   cyc = 0;
    int   img [H][W];
    vec_t vt [8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [8:0][7:0] mk_k(input int idx, input int w, input int rest);
        logic [8:0][7:0] k;
        for (int i = 0; i < 9; i++) k[i] = (i == idx) ? 8'(w) : 8'(rest);
        return k;
    endfunction

    function automatic int model(input int r, input int c, input logic [8:0][7:0] k, input int sh);
        int s = 0;
        for (int kr = 0; kr < 3; kr++)
            for (int kc = 0; kc < 3; kc++)
                s += img[r-1+kr][c-1+kc] * int'($signed(k[3*kr+kc]));
        s = s >>> sh;
        if (s < 0)   return 0;
        if (s > 255) return 255;
        return s;
    endfunction

    task automatic drive(input logic v, input int p);
        bus0.pix_valid = v;
        bus3.pix_valid = v;
        bus0.pix_in    = 8'(p);
        bus3.pix_in    = 8'(p);
    endtask

    task automatic push_exp(input int r, input int c, input logic [8:0][7:0] k);
        exp_t e;
        e.due = cyc + 2;
        e.val = model(r - 1, c - 1, k, 0);
        q0.push_back(e);
        e.val = model(r - 1, c - 1, k, 3);
        q3.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus0.En) begin
            log0.push_back(int'(bus0.convResult));
            if (q0.size() == 0) chk("unexpected_en0", 1, 0);
            else begin
                e = q0.pop_front();
                chk("res0", int'(bus0.convResult), e.val);
                chk("lat0", cyc, e.due);
            end
        end
        if (bus3.En) begin
            log3.push_back(int'(bus3.convResult));
            if (q3.size() == 0) chk("unexpected_en3", 1, 0);
            else begin
                e = q3.pop_front();
                chk("res3", int'(bus3.convResult), e.val);
                chk("lat3", cyc, e.due);
            end
        end
        if (fd0) chk("fd_with_en0", int'(bus0.En), 0);
    end

    task automatic run_frame(input vec_t v, input string nm);
        int  b0 = log0.size();
        int  b3 = log3.size();
        int  klast = 0, p, f0, l0, f3, l3;
        bit  got = 1'b0;
        @(negedge clk);
        start = 1'b1; kernel = v.k;
        @(negedge clk);
        start = 1'b0;
        chk({nm, "_busy_run"}, int'(busy0), 1);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                start = 1'b0; kernel = v.k;
                if (v.gap) begin
                    drive(1'b0, 0);
                    @(negedge clk);
                end
                p = (v.pmode == 0) ? 8 * r + c : v.pval;
                img[r][c] = p;
                drive(1'b1, p);
                if (v.disturb && r * W + c == 30) begin
                    start = 1'b1; kernel = mk_k(4, 1, 1);
                end
                if (r >= 2 && c >= 2) push_exp(r, c, v.k);
                klast = cyc;
                @(negedge clk);
            end
        end
        drive(1'b0, 0);
        start = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (fd0) begin got = 1'b1; break; end
            @(negedge clk);
        end
        if (got) chk({nm, "_frame_done_cyc"}, cyc, klast + 3);
        else     chk({nm, "_frame_done_timeout"}, 0, 1);
        chk({nm, "_fd3"}, int'(fd3), 1);
        chk({nm, "_busy_idle"}, int'(busy0), 0);
        @(negedge clk);
        chk({nm, "_cnt0"}, log0.size() - b0, NWIN);
        chk({nm, "_cnt3"}, log3.size() - b3, NWIN);
        f0 = (log0.size() > b0) ? log0[b0] : -1;
        l0 = (log0.size() > b0) ? log0[log0.size()-1] : -1;
        f3 = (log3.size() > b3) ? log3[b3] : -1;
        l3 = (log3.size() > b3) ? log3[log3.size()-1] : -1;
        chk({nm, "_first0"}, f0, v.first0);
        chk({nm, "_last0"},  l0, v.last0);
        chk({nm, "_first3"}, f3, v.first3);
        chk({nm, "_last3"},  l3, v.last3);
        chk({nm, "_sb_empty"}, q0.size() + q3.size(), 0);
    endtask

    initial begin
        int base, p;
        vt[0] = '{mk_k(4, 1, 0),  0, 0,   1'b0, 1'b0, 9,   54,  1,   6};
        vt[1] = '{mk_k(4, 1, 1),  1, 100, 1'b0, 1'b0, 255, 255, 112, 112};
        vt[2] = '{mk_k(4, -1, 0), 1, 50,  1'b0, 1'b0, 0,   0,   0,   0};
        vt[3] = '{mk_k(4, 1, 0),  0, 0,   1'b1, 1'b0, 9,   54,  1,   6};
        vt[4] = '{mk_k(0, 2, 0),  0, 0,   1'b0, 1'b0, 0,   90,  0,   11};
        vt[5] = '{mk_k(8, 1, 0),  0, 0,   1'b0, 1'b0, 18,  63,  2,   7};
        vt[6] = '{mk_k(4, 8, -1), 0, 0,   1'b0, 1'b0, 0,   0,   0,   0};
        vt[7] = '{mk_k(4, 1, 0),  0, 0,   1'b0, 1'b1, 9,   54,  1,   6};

        drive(1'b0, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_conv", int'(bus0.convResult), 0);
        chk("rst_en",   int'(bus0.En), 0);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_fd",   int'(fd0), 0);
        rst = 1'b0;
        @(negedge clk);

        run_frame(vt[0], "T1_identity");
        run_frame(vt[1], "T2_saturate");
        run_frame(vt[2], "T3_negative");
        run_frame(vt[3], "T4_gaps");
        run_frame(vt[4], "topleft");
        run_frame(vt[5], "bottomright");
        run_frame(vt[6], "laplacian");

        // reset in the middle of a frame, with one result still in flight
        @(negedge clk);
        start = 1'b1; kernel = vt[0].k;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 20; n++) begin
            p = 8 * (n / W) + (n % W);
            img[n / W][n % W] = p;
            drive(1'b1, p);
            if (n / W >= 2 && n % W >= 2) push_exp(n / W, n % W, vt[0].k);
            @(negedge clk);
        end
        rst = 1'b1;
        drive(1'b0, 0);
        @(negedge clk);
        chk("T5_en0",   int'(bus0.En), 0);
        chk("T5_busy0", int'(busy0), 0);
        chk("T5_conv0", int'(bus0.convResult), 0);
        chk("T5_en3",   int'(bus3.En), 0);
        chk("T5_busy3", int'(busy3), 0);
        q0.delete();
        q3.delete();
        rst = 1'b0;
        run_frame(vt[0], "T5_rerun");

        // pixels offered while idle must not produce anything
        base = log0.size();
        for (int n = 0; n < 10; n++) begin
            drive(1'b1, 77);
            @(negedge clk);
        end
        drive(1'b0, 0);
        repeat (4) @(negedge clk);
        chk("T6_idle_no_en", log0.size() - base, 0);
        chk("T6_idle_busy",  int'(busy0), 0);

        run_frame(vt[7], "T6_start_in_run");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
